// File: rtl/lsu_pkg.sv
// Shared types for the load/store memory stage: access sizes, FSM states and
// the word-offset width used to split an effective address.
package lsu_pkg;

  localparam int WORD_OFF_W = 2;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } lsu_state_e;

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/half lane out of a memory read word and extends it
// to a full register value; words pass straight through.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0]           rdata,
  input  logic [WORD_OFF_W-1:0] offset,
  input  lsu_size_e             size,
  input  logic                  is_unsigned,
  output logic [31:0]           ext_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata[{offset, 3'b000} +: 8];
    half_lane = offset[1] ? rdata[31:16] : rdata[15:0];
    ext_data  = '0;
    case (size)
      SZ_BYTE: ext_data = {{24{byte_lane[7] & ~is_unsigned}}, byte_lane};
      SZ_HALF: ext_data = {{16{half_lane[15] & ~is_unsigned}}, half_lane};
      SZ_WORD: ext_data = rdata;
      default: ext_data = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store memory stage: takes one access from the pipeline, issues a single
// word-aligned memory request, and returns extended load data or completion.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("lsu_mem_stage supports DATA_WIDTH = 32 only");
  end

  // Handshakes: a request is taken on a rising edge where req_valid && req_ready;
  // mem_req and every mem_* output then stay constant up to and including the
  // edge where mem_ack is sampled high. resp_valid is a single-cycle pulse.

  lsu_state_e            state_q, state_d;
  logic                  we_q, we_d;
  lsu_size_e             size_q, size_d;
  logic                  uns_q, uns_d;
  logic [WORD_OFF_W-1:0] off_q, off_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  lsu_size_e             req_size_e;
  logic [3:0]            be_calc;
  logic [DATA_WIDTH-1:0] wdata_lanes;
  logic [DATA_WIDTH-1:0] load_ext;
  logic                  misaligned;

  assign req_size_e = lsu_size_e'(req_size);

  always_comb begin
    be_calc     = 4'b0000;
    wdata_lanes = req_wdata;
    misaligned  = 1'b0;
    case (req_size_e)
      SZ_BYTE: begin
        be_calc     = 4'b0001 << req_addr[1:0];
        wdata_lanes = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        be_calc     = 4'b0011 << {req_addr[1], 1'b0};
        wdata_lanes = {2{req_wdata[15:0]}};
        misaligned  = req_addr[0];
      end
      SZ_WORD: begin
        be_calc    = 4'b1111;
        misaligned = |req_addr[1:0];
      end
      default: misaligned = 1'b1;
    endcase
  end

  lsu_load_align u_load_align (
    .rdata       (mem_rdata),
    .offset      (off_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .ext_data    (load_ext)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    off_d   = off_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size_e;
          uns_d   = req_unsigned;
          off_d   = req_addr[WORD_OFF_W-1:0];
          addr_d  = {req_addr[ADDR_WIDTH-1:WORD_OFF_W], {WORD_OFF_W{1'b0}}};
          be_d    = be_calc;
          wdata_d = wdata_lanes;
          rdata_d = '0;
          err_d   = misaligned;
          state_d = misaligned ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          rdata_d = we_q ? '0 : load_ext;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      off_q   <= '0;
      addr_q  <= '0;
      be_q    <= 4'b0000;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Memory outputs are forced to zero outside ACCESS so idle/reset values are clean.
  assign req_ready  = (state_q == IDLE);
  assign stall      = req_valid & ~req_ready;
  assign mem_req    = (state_q == ACCESS);
  assign mem_we     = mem_req & we_q;
  assign mem_addr   = mem_req ? addr_q : '0;
  assign mem_be     = mem_req ? be_q : 4'b0000;
  assign mem_wdata  = mem_req ? wdata_q : '0;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign resp_err   = resp_valid & err_q;

endmodule
